// File: rtl/spatz_lane_sequencer.sv
// Lane sequencer: accepts a per-lane vector request, streams operand triples
// into one SIMD lane, collects each lane result and forwards it on an indexed
// result stream. Divide ops get a forced valid gap between elements so the
// serial divider never restarts on stale operands.
package spatz_lane_pkg;

    typedef enum logic [4:0] {
        VADD, VSUB, VADC, VSBC, VMUL, VMULH, VMACC, VDIVU, VDIV, VREMU, VREM,
        VAND, VOR, VXOR, VMIN, VMAX
    } op_e;

    typedef enum logic [1:0] {
        EW_8, EW_16, EW_32, EW_64
    } vew_e;

endpackage

module spatz_lane_sequencer
    import spatz_lane_pkg::*;
#(
    parameter int unsigned Width   = 8,
    parameter int unsigned VlWidth = 8,
    parameter type         data_t  = logic [Width-1:0]
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // Vector request
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  op_e                req_op_i,
    input  logic [VlWidth-1:0] req_vl_i,
    input  vew_e               req_sew_i,
    input  logic               req_signed_i,
    // Operand stream
    input  logic               opd_valid_i,
    output logic               opd_ready_o,
    input  data_t              opd_s1_i,
    input  data_t              opd_s2_i,
    input  data_t              opd_d_i,
    input  logic               opd_carry_i,
    // Lane issue side
    output op_e                lane_operation_o,
    output logic               lane_operation_valid_o,
    output data_t              lane_op_s1_o,
    output data_t              lane_op_s2_o,
    output data_t              lane_op_d_o,
    output logic               lane_is_signed_o,
    output logic               lane_carry_o,
    output vew_e               lane_sew_o,
    // Lane result side
    input  data_t              lane_result_i,
    input  logic               lane_result_valid_i,
    output logic               lane_result_ready_o,
    // Result stream
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output data_t              res_data_o,
    output logic [VlWidth-1:0] res_idx_o,
    output logic               res_last_o,
    // Status
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        DRAIN
    } state_e;

    localparam logic [VlWidth-1:0] VlOne = {{(VlWidth-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [VlWidth-1:0] vl_q;
    logic [VlWidth-1:0] issue_cnt_q;
    logic [VlWidth-1:0] res_cnt_q;
    logic               div_gap_q;

    logic               is_div;
    logic               lane_hs;
    logic               last_res;
    logic               opd_hs;
    logic               res_pop;

    assign is_div   = lane_operation_o inside {VDIV, VDIVU, VREM, VREMU};
    assign last_res = (res_cnt_q == (vl_q - VlOne));
    assign res_pop  = res_valid_o && res_ready_i;

    // The lane may hand over a result only while executing and while the
    // single-entry output register is empty or being drained this cycle.
    assign lane_result_ready_o = (state_q == EXEC) && (!res_valid_o || res_ready_i);
    assign lane_hs             = lane_result_valid_i && lane_result_ready_o;

    // Operands are taken while fetching, or in the result handshake cycle of a
    // non-final element so single-cycle ops run at one element per cycle.
    assign opd_ready_o = (state_q == FETCH) ||
                         ((state_q == EXEC) && lane_hs && !last_res && (issue_cnt_q < vl_q));
    assign opd_hs      = opd_valid_i && opd_ready_o;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

    // Sequencer FSM together with the lane operand, output and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q                <= IDLE;
            vl_q                   <= '0;
            issue_cnt_q            <= '0;
            res_cnt_q              <= '0;
            div_gap_q              <= 1'b0;
            lane_operation_o       <= VADD;
            lane_operation_valid_o <= 1'b0;
            lane_op_s1_o           <= '0;
            lane_op_s2_o           <= '0;
            lane_op_d_o            <= '0;
            lane_is_signed_o       <= 1'b0;
            lane_carry_o           <= 1'b0;
            lane_sew_o             <= EW_8;
            res_valid_o            <= 1'b0;
            res_data_o             <= '0;
            res_idx_o              <= '0;
            res_last_o             <= 1'b0;
            done_o                 <= 1'b0;
        end else begin
            done_o <= 1'b0;

            if (res_pop) begin
                res_valid_o <= 1'b0;
            end

            if (lane_hs) begin
                res_valid_o <= 1'b1;
                res_data_o  <= lane_result_i;
                res_idx_o   <= res_cnt_q;
                res_last_o  <= last_res;
                res_cnt_q   <= res_cnt_q + VlOne;
            end

            if (opd_hs) begin
                lane_op_s1_o <= opd_s1_i;
                lane_op_s2_o <= opd_s2_i;
                lane_op_d_o  <= opd_d_i;
                lane_carry_o <= opd_carry_i;
                issue_cnt_q  <= issue_cnt_q + VlOne;
            end

            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        lane_operation_o <= req_op_i;
                        vl_q             <= req_vl_i;
                        lane_sew_o       <= req_sew_i;
                        lane_is_signed_o <= req_signed_i;
                        issue_cnt_q      <= '0;
                        res_cnt_q        <= '0;
                        div_gap_q        <= 1'b0;
                        if (req_vl_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (opd_valid_i) begin
                        lane_operation_valid_o <= 1'b1;
                        state_q                <= EXEC;
                    end
                end
                EXEC: begin
                    if (div_gap_q) begin
                        lane_operation_valid_o <= 1'b1;
                        div_gap_q              <= 1'b0;
                    end
                    if (lane_hs) begin
                        if (last_res) begin
                            lane_operation_valid_o <= 1'b0;
                            state_q                <= DRAIN;
                        end else if (opd_valid_i) begin
                            lane_operation_valid_o <= !is_div;
                            div_gap_q              <= is_div;
                        end else begin
                            lane_operation_valid_o <= 1'b0;
                            state_q                <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (res_pop && res_last_o) begin
                        done_o  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spatz_lane_sequencer.sv
// Testbench for spatz_lane_sequencer: a behavioural lane (single-cycle ALU plus
// a multi-cycle divider), queue-driven operand stream and a result scoreboard.
module tb_spatz_lane_sequencer;
    import spatz_lane_pkg::*;

    localparam int Width   = 8;
    localparam int VlWidth = 8;
    localparam int DivLat  = 3;

    typedef logic [Width-1:0] data_t;

    typedef struct {
        data_t s1;
        data_t s2;
        data_t d;
        logic  c;
    } opd_t;

    typedef struct {
        data_t             data;
        logic [VlWidth-1:0] idx;
        logic              last;
    } exp_t;

    logic               clk_i;
    logic               rst_ni;
    logic               req_valid_i;
    logic               req_ready_o;
    op_e                req_op_i;
    logic [VlWidth-1:0] req_vl_i;
    vew_e               req_sew_i;
    logic               req_signed_i;
    logic               opd_valid_i;
    logic               opd_ready_o;
    data_t              opd_s1_i;
    data_t              opd_s2_i;
    data_t              opd_d_i;
    logic               opd_carry_i;
    op_e                lane_operation_o;
    logic               lane_operation_valid_o;
    data_t              lane_op_s1_o;
    data_t              lane_op_s2_o;
    data_t              lane_op_d_o;
    logic               lane_is_signed_o;
    logic               lane_carry_o;
    vew_e               lane_sew_o;
    data_t              lane_result_i;
    logic               lane_result_valid_i;
    logic               lane_result_ready_o;
    logic               res_valid_o;
    logic               res_ready_i;
    data_t              res_data_o;
    logic [VlWidth-1:0] res_idx_o;
    logic               res_last_o;
    logic               busy_o;
    logic               done_o;

    int num_checks = 0;
    int num_errors = 0;
    int cyc = 0;

    opd_t opd_q[$];
    exp_t exp_q[$];

    op_e  exp_op;
    vew_e exp_sew;
    logic exp_signed;
    logic exp_carry;
    int   accept_cnt;
    int   first_accept_cyc;
    int   last_accept_cyc;
    int   stall_cnt = 0;
    logic stall_arm;
    logic saw_opd_ready;
    logic saw_lane_valid;
    logic prev_lane_hs = 1'b0;
    logic prev_div = 1'b0;

    logic  div_busy;
    logic  div_done;
    int    div_cnt;
    data_t div_res;

    spatz_lane_sequencer #(
        .Width   (Width),
        .VlWidth (VlWidth)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_op_i               (req_op_i),
        .req_vl_i               (req_vl_i),
        .req_sew_i              (req_sew_i),
        .req_signed_i           (req_signed_i),
        .opd_valid_i            (opd_valid_i),
        .opd_ready_o            (opd_ready_o),
        .opd_s1_i               (opd_s1_i),
        .opd_s2_i               (opd_s2_i),
        .opd_d_i                (opd_d_i),
        .opd_carry_i            (opd_carry_i),
        .lane_operation_o       (lane_operation_o),
        .lane_operation_valid_o (lane_operation_valid_o),
        .lane_op_s1_o           (lane_op_s1_o),
        .lane_op_s2_o           (lane_op_s2_o),
        .lane_op_d_o            (lane_op_d_o),
        .lane_is_signed_o       (lane_is_signed_o),
        .lane_carry_o           (lane_carry_o),
        .lane_sew_o             (lane_sew_o),
        .lane_result_i          (lane_result_i),
        .lane_result_valid_i    (lane_result_valid_i),
        .lane_result_ready_o    (lane_result_ready_o),
        .res_valid_o            (res_valid_o),
        .res_ready_i            (res_ready_i),
        .res_data_o             (res_data_o),
        .res_idx_o              (res_idx_o),
        .res_last_o             (res_last_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o)
    );

    // Free-running clock and a cycle counter used for timing checks.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic is_div_op(input op_e op);
        return op inside {VDIV, VDIVU, VREM, VREMU};
    endfunction

    function automatic data_t lane_model(input op_e op, input data_t s1, input data_t s2,
                                         input data_t d, input logic c);
        data_t r;
        case (op)
            VADD:    r = s2 + s1;
            VADC:    r = s2 + s1 + data_t'(c);
            VMUL:    r = s2 * s1;
            VMACC:   r = s2 * s1 + d;
            VDIVU:   r = (s1 == '0) ? '1 : s2 / s1;
            VREMU:   r = (s1 == '0) ? s2 : s2 % s1;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Behavioural serial divider: latches operands on start, answers DivLat cycles later.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_cnt  <= 0;
            div_res  <= '0;
        end else begin
            if (div_done && lane_result_ready_o) div_done <= 1'b0;
            if (div_busy) begin
                if (div_cnt == 1) begin
                    div_busy <= 1'b0;
                    div_done <= 1'b1;
                end else begin
                    div_cnt <= div_cnt - 1;
                end
            end else if (!div_done && lane_operation_valid_o && is_div_op(lane_operation_o)) begin
                div_busy <= 1'b1;
                div_cnt  <= DivLat;
                div_res  <= lane_model(lane_operation_o, lane_op_s1_o, lane_op_s2_o,
                                       lane_op_d_o, lane_carry_o);
            end
        end
    end

    // Single-cycle ops answer combinationally; divides answer from the divider model.
    always_comb begin
        lane_result_valid_i = lane_operation_valid_o;
        lane_result_i       = lane_model(lane_operation_o, lane_op_s1_o, lane_op_s2_o,
                                         lane_op_d_o, lane_carry_o);
        if (is_div_op(lane_operation_o)) begin
            lane_result_valid_i = div_done;
            lane_result_i       = div_res;
        end
    end

    // Operand stream driver: presents the queue head, pops it once consumed.
    initial begin : opd_driver
        logic take;
        opd_valid_i = 1'b0;
        opd_s1_i = '0;
        opd_s2_i = '0;
        opd_d_i = '0;
        opd_carry_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (opd_q.size() > 0) begin
                opd_valid_i = 1'b1;
                opd_s1_i    = opd_q[0].s1;
                opd_s2_i    = opd_q[0].s2;
                opd_d_i     = opd_q[0].d;
                opd_carry_i = opd_q[0].c;
            end else begin
                opd_valid_i = 1'b0;
                opd_s1_i    = '0;
                opd_s2_i    = '0;
                opd_d_i     = '0;
                opd_carry_i = 1'b0;
            end
            #1;
            take = opd_valid_i && opd_ready_o && rst_ni;
            @(posedge clk_i);
            if (take && opd_q.size() > 0) void'(opd_q.pop_front());
        end
    end

    // Monitor: drives result backpressure and scores every accepted result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (stall_cnt > 0) begin
                res_ready_i = 1'b0;
                stall_cnt--;
            end else begin
                res_ready_i = 1'b1;
            end
            #2;
            if (rst_ni) begin
                if (opd_ready_o) saw_opd_ready = 1'b1;
                if (lane_operation_valid_o) begin
                    saw_lane_valid = 1'b1;
                    check_output("lane_op", 64'(lane_operation_o), 64'(exp_op));
                    check_output("lane_sew", 64'(lane_sew_o), 64'(exp_sew));
                    check_output("lane_signed", 64'(lane_is_signed_o), 64'(exp_signed));
                    if (exp_op == VADC) check_output("lane_carry", 64'(lane_carry_o), 64'(exp_carry));
                end
                if (div_busy) check_output("div_valid_held", 64'(lane_operation_valid_o), 64'd1);
                if (prev_lane_hs && prev_div) check_output("div_gap", 64'(lane_operation_valid_o), 64'd0);
                prev_lane_hs = lane_result_valid_i && lane_result_ready_o;
                prev_div     = is_div_op(lane_operation_o);
                if (res_valid_o && !res_ready_i)
                    check_output("backpressure_lane_ready", 64'(lane_result_ready_o), 64'd0);
                if (res_valid_o && res_ready_i) begin
                    if (exp_q.size() == 0) begin
                        num_checks++;
                        num_errors++;
                        $display("[TB] FAIL unexpected_result: got idx %0d data 0x%0h, expected none",
                                 res_idx_o, res_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("res_data", 64'(res_data_o), 64'(e.data));
                        check_output("res_idx", 64'(res_idx_o), 64'(e.idx));
                        check_output("res_last", 64'(res_last_o), 64'(e.last));
                    end
                    if (accept_cnt == 0) first_accept_cyc = cyc;
                    accept_cnt++;
                    last_accept_cyc = cyc;
                    if (stall_arm) begin
                        stall_cnt = 5;
                        stall_arm = 1'b0;
                    end
                end
            end else begin
                prev_lane_hs = 1'b0;
            end
        end
    end

    task automatic push_element(input data_t s1, input data_t s2, input logic c,
                                input data_t res, input int idx, input logic last);
        opd_t o;
        exp_t e;
        o.s1 = s1;
        o.s2 = s2;
        o.d  = '0;
        o.c  = c;
        opd_q.push_back(o);
        e.data = res;
        e.idx  = VlWidth'(idx);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic issue_request(input op_e op, input int vl, input vew_e sew, input logic sgn);
        exp_op     = op;
        exp_sew    = sew;
        exp_signed = sgn;
        accept_cnt = 0;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_op_i     = op;
        req_vl_i     = VlWidth'(vl);
        req_sew_i    = sew;
        req_signed_i = sgn;
        #1;
        check_output("req_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic apply_stimulus(input op_e op, input int vl, input vew_e sew, input logic sgn);
        logic done_seen;
        int   done_cyc;
        int   extra;
        done_seen = 1'b0;
        done_cyc  = 0;
        extra     = 0;
        issue_request(op, vl, sew, sgn);
        for (int i = 0; i < 300; i++) begin
            #2;
            if (done_o) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                break;
            end
            @(negedge clk_i);
        end
        check_output("done_seen", 64'(done_seen), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #2;
            if (done_o) extra++;
        end
        check_output("done_single", 64'(extra), 64'd0);
        check_output("elem_count", 64'(accept_cnt), 64'(vl));
        check_output("sb_drained", 64'(exp_q.size()), 64'd0);
        if (vl > 0 && done_seen) check_output("done_timing", 64'(done_cyc - last_accept_cyc), 64'd1);
    endtask

    // Directed test sequence.
    initial begin : main
        logic got_valid;
        int   post_done;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_op_i     = VADD;
        req_vl_i     = '0;
        req_sew_i    = EW_8;
        req_signed_i = 1'b0;
        res_ready_i  = 1'b1;
        exp_op       = VADD;
        exp_sew      = EW_8;
        exp_signed   = 1'b0;
        exp_carry    = 1'b0;
        stall_arm    = 1'b0;
        accept_cnt   = 0;
        saw_opd_ready  = 1'b0;
        saw_lane_valid = 1'b0;
        first_accept_cyc = 0;
        last_accept_cyc  = 0;

        #3;
        check_output("rst_req_ready", 64'(req_ready_o), 64'd1);
        check_output("rst_opd_ready", 64'(opd_ready_o), 64'd0);
        check_output("rst_lane_valid", 64'(lane_operation_valid_o), 64'd0);
        check_output("rst_lane_res_ready", 64'(lane_result_ready_o), 64'd0);
        check_output("rst_res_valid", 64'(res_valid_o), 64'd0);
        check_output("rst_busy", 64'(busy_o), 64'd0);
        check_output("rst_done", 64'(done_o), 64'd0);
        check_output("rst_sew", 64'(lane_sew_o), 64'(EW_8));
        check_output("rst_op", 64'(lane_operation_o), 64'(VADD));
        check_output("rst_res_data", 64'(res_data_o), 64'd0);
        check_output("rst_res_idx", 64'(res_idx_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] VADD vl=4 streaming");
        push_element(8'h01, 8'h02, 1'b0, 8'h03, 0, 1'b0);
        push_element(8'h03, 8'h04, 1'b0, 8'h07, 1, 1'b0);
        push_element(8'hFF, 8'h01, 1'b0, 8'h00, 2, 1'b0);
        push_element(8'h07, 8'h08, 1'b0, 8'h0F, 3, 1'b1);
        apply_stimulus(VADD, 4, EW_8, 1'b0);
        check_output("vadd_back_to_back", 64'(last_accept_cyc - first_accept_cyc), 64'd3);

        $display("[TB] VDIVU vl=2 with divider latency");
        push_element(8'h03, 8'h0A, 1'b0, 8'h03, 0, 1'b0);
        push_element(8'h00, 8'h05, 1'b0, 8'hFF, 1, 1'b1);
        apply_stimulus(VDIVU, 2, EW_8, 1'b0);

        $display("[TB] VMUL vl=3 with result backpressure");
        push_element(8'h02, 8'h03, 1'b0, 8'h06, 0, 1'b0);
        push_element(8'h04, 8'h05, 1'b0, 8'h14, 1, 1'b0);
        push_element(8'h10, 8'h10, 1'b0, 8'h00, 2, 1'b1);
        stall_arm = 1'b1;
        apply_stimulus(VMUL, 3, EW_16, 1'b1);

        $display("[TB] vl=0 request");
        saw_opd_ready  = 1'b0;
        saw_lane_valid = 1'b0;
        apply_stimulus(VADD, 0, EW_32, 1'b0);
        check_output("vl0_no_opd_ready", 64'(saw_opd_ready), 64'd0);
        check_output("vl0_no_lane_valid", 64'(saw_lane_valid), 64'd0);

        $display("[TB] VADC vl=2 with carry");
        exp_carry = 1'b1;
        push_element(8'hFF, 8'h00, 1'b1, 8'h00, 0, 1'b0);
        push_element(8'h01, 8'h01, 1'b1, 8'h03, 1, 1'b1);
        apply_stimulus(VADC, 2, EW_8, 1'b0);
        exp_carry = 1'b0;

        $display("[TB] reset during EXEC");
        begin
            opd_t o;
            o.s1 = 8'h01;
            o.s2 = 8'h01;
            o.d  = '0;
            o.c  = 1'b0;
            opd_q.push_back(o);
        end
        issue_request(VDIVU, 1, EW_8, 1'b0);
        got_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (lane_operation_valid_o) begin
                got_valid = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check_output("rst_mid_exec_reached", 64'(got_valid), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_output("rst_mid_lane_valid", 64'(lane_operation_valid_o), 64'd0);
        check_output("rst_mid_res_valid", 64'(res_valid_o), 64'd0);
        check_output("rst_mid_opd_ready", 64'(opd_ready_o), 64'd0);
        check_output("rst_mid_req_ready", 64'(req_ready_o), 64'd1);
        check_output("rst_mid_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        post_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            #2;
            if (done_o) post_done++;
        end
        check_output("rst_mid_no_done", 64'(post_done), 64'd0);
        check_output("rst_mid_no_result", 64'(accept_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
